// File: rtl/onehot_state_encoder.sv
// onehot_state_encoder: converts a one-hot position enable vector back into
// a state index (0 = no state). The stage holds one registered result and
// uses valid/ready handshakes on both sides. Malformed vectors (none-hot or
// multi-hot) are flagged and counted in a saturating error counter.
// Optional feature macro: ONEHOT_ENC_HOLD_LAST_EN -- when defined, malformed
// vectors report the most recent well-formed index instead of 0 or the
// lowest set bit.
module onehot_state_encoder #(
  parameter int N_STATES  = 15,
  parameter int AT_W      = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_STATES-1:0]  en_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AT_W-1:0]      at,
  output logic                 none_hot,
  output logic                 multi_hot,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 out_valid_q, out_valid_d;
  logic [AT_W-1:0]      at_q, at_d;
  logic                 none_q, none_d;
  logic                 multi_q, multi_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
`ifdef ONEHOT_ENC_HOLD_LAST_EN
  logic [AT_W-1:0]      last_q, last_d;
`endif

  logic                 accept;
  logic                 none_c, multi_c;
  logic [AT_W-1:0]      low_c;

  // The slot frees up when it is empty or being drained this cycle.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Classify the incoming vector and find its lowest set bit (index+1).
  always_comb begin
    none_c  = ~|en_vec;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    multi_c = |(en_vec & (en_vec - N_STATES'(1)));
    low_c   = '0;
    for (int i = N_STATES - 1; i >= 0; i--) begin
      if (en_vec[i]) low_c = AT_W'(i + 1);
    end
  end

  // Next-state for the output slot, error counter and last-valid index.
  always_comb begin
    out_valid_d = out_valid_q;
    at_d        = at_q;
    none_d      = none_q;
    multi_d     = multi_q;
    err_d       = err_q;
`ifdef ONEHOT_ENC_HOLD_LAST_EN
    last_d      = last_q;
`endif
    // en_vec is only looked at on an accept, so garbage on an idle bus
    // never reaches the registers.
    if (accept) begin
      out_valid_d = 1'b1;
      none_d      = none_c;
      multi_d     = multi_c;
`ifdef ONEHOT_ENC_HOLD_LAST_EN
      if (none_c || multi_c) begin
        at_d = last_q;
      end else begin
        at_d   = low_c;
        last_d = low_c;
      end
`else
      at_d = low_c;
`endif
      if ((none_c || multi_c) && (err_q != {ERR_CNT_W{1'b1}}))
        err_d = err_q + ERR_CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      at_q        <= '0;
      none_q      <= 1'b0;
      multi_q     <= 1'b0;
      err_q       <= '0;
`ifdef ONEHOT_ENC_HOLD_LAST_EN
      last_q      <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      at_q        <= at_d;
      none_q      <= none_d;
      multi_q     <= multi_d;
      err_q       <= err_d;
`ifdef ONEHOT_ENC_HOLD_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign at        = at_q;
  assign none_hot  = none_q;
  assign multi_hot = multi_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_onehot_state_encoder.sv
// Scoreboard bench for onehot_state_encoder: the driver pushes the expected
// result of every accepted vector; a negedge monitor compares what the DUT
// presents against the queue head and pops on each consume.
module tb_onehot_state_encoder;

  localparam int N  = 15;
  localparam int AW = 4;
  localparam int EW = 8;

  typedef struct {
    logic [AW-1:0] at;
    logic          none;
    logic          multi;
  } exp_t;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  en_vec;
  logic [AW-1:0] at;
  logic          none_hot, multi_hot;
  logic [EW-1:0] err_count;

  onehot_state_encoder #(.N_STATES(N), .AT_W(AW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .en_vec(en_vec), .out_valid(out_valid), .out_ready(out_ready),
    .at(at), .none_hot(none_hot), .multi_hot(multi_hot),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_err  = 0;
  int   m_last = 0;
  bit   started = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: count set bits and locate the lowest one directly.
  task automatic model(input logic [N-1:0] e);
    exp_t r;
    int   n, low;
    n = $countones(e);
    low = -1;
    for (int i = 0; i < N; i++) if (e[i] && low < 0) low = i;
    r.none  = (n == 0);
    r.multi = (n >= 2);
    r.at    = (n == 0) ? '0 : AW'(low + 1);
`ifdef ONEHOT_ENC_HOLD_LAST_EN
    if (n != 1) r.at = AW'(m_last);
`endif
    if (n == 1) m_last = low + 1;
    else if (m_err < (1 << EW) - 1) m_err++;
    q.push_back(r);
  endtask

  // One cycle: drive, decide accept before the edge, record after it.
  task automatic step(input logic v, input logic [N-1:0] e, input logic r);
    bit acc;
    in_valid  = v;
    en_vec    = e;
    out_ready = r;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_err  = 0;
      m_last = 0;
    end else if (acc) begin
      model(e);
    end
    #1;
  endtask

  // Monitor: handshake signals every cycle, held result against queue head.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("in_ready", int'(in_ready), int'(!rst && (q.size() == 0 || out_ready)));
      chk("err_count", int'(err_count), m_err);
      if (out_valid && q.size() != 0) begin
        chk("at", int'(at), int'(q[0].at));
        chk("none_hot", int'(none_hot), int'(q[0].none));
        chk("multi_hot", int'(multi_hot), int'(q[0].multi));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; en_vec = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    started = 1;
    step(1'b0, '0, 1'b0);          // still in reset: in_ready must be 0
    rst = 1'b0;
    chk("rst_at", int'(at), 0);
    chk("rst_flags", int'({none_hot, multi_hot}), 0);

    // Walk every single-hot position, including the top bit -> 15.
    for (int k = 0; k < N; k++) step(1'b1, N'(1) << k, 1'b1);
    step(1'b0, '0, 1'b1);

    // Malformed vectors, optionally after a well-formed 0x0100.
    step(1'b1, 15'h0100, 1'b1);
    step(1'b1, 15'h0000, 1'b1);
    step(1'b1, 15'h0014, 1'b1);
    step(1'b0, '0, 1'b1);

    // Backpressure: result 7 held for 5 cycles, then 2 follows.
    step(1'b1, 15'h0040, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 15'h0002, 1'b0);
    step(1'b1, 15'h0002, 1'b1);
    step(1'b0, '0, 1'b1);

    // Back-to-back, simultaneous consume and accept.
    for (int i = 0; i < 4; i++) step(1'b1, N'(1) << (i + 3), 1'b1);
    step(1'b0, '0, 1'b1);

    // Randomized traffic with idle-bus garbage and random backpressure.
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] e;
      case ($urandom_range(0, 3))
        0:       e = N'(1) << $urandom_range(0, N - 1);
        1:       e = '0;
        default: e = N'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, '0, 1'b1);

    // Saturation: 300 all-zero vectors pin the counter at 255.
    for (int i = 0; i < 300; i++) step(1'b1, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("err_sat", int'(err_count), 255);

    // Mid-operation reset while a result is stalled.
    step(1'b1, 15'h0008, 1'b0);
    rst = 1'b1;
    step(1'b1, 15'h0010, 1'b0);
    rst = 1'b0;
    step(1'b0, '0, 1'b1);
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_err", int'(err_count), 0);

    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_state_encoder.md
Name: onehot_state_encoder

Overview:
- Inverse of the maze-state decoder: converts the 15-line one-hot position enable vector (en1..en15) back to the 4-bit state index `at`, where 0 means no state.
- Registered, single-entry pipeline stage with valid/ready handshakes on both sides.
- Flags malformed vectors (none-hot or multi-hot) and counts them in a saturating error counter.
- Sits between the maze environment / position logic and the Q-table address path of the MazeSolver.

Parameters:
- N_STATES, 15, number of enable lines; bit k corresponds to state k+1.
- AT_W, 4, width of the encoded state index; must satisfy 2**AT_W > N_STATES.
- ERR_CNT_W, 8, width of the saturating malformed-vector counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  en_vec is valid this cycle.
- in_ready  output  1  block accepts en_vec this cycle.
- en_vec  input  N_STATES  one-hot enables; bit 0 = en1 ... bit 14 = en15.
- out_valid  output  1  at and the flags hold a result.
- out_ready  input  1  downstream consumes the result this cycle.
- at  output  AT_W  encoded state index, 0..15.
- none_hot  output  1  result came from an all-zero vector.
- multi_hot  output  1  result came from a vector with 2 or more bits set.
- err_count  output  ERR_CNT_W  saturating count of accepted malformed vectors.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, at=0, none_hot=0, multi_hot=0, err_count=0, last-valid register=0. in_ready is forced to 0 while rst=1.
- Reset mid-operation: any result held in the output register is discarded, with no out_valid pulse. Reset has priority over all other events in the same cycle.
- in_ready = !rst && (!out_valid || out_ready). This is combinational and allows full throughput of 1 vector per cycle.
- Accept: in_valid && in_ready at a rising edge. The result is registered with exactly 1-cycle latency, and out_valid=1 on the next cycle.
- Consume: out_valid && out_ready at a rising edge. If no new accept happens in the same cycle, out_valid drops to 0.
- Simultaneous consume and accept: out_valid stays 1 and the output register loads the new result. No bubble, no loss.
- Stall: while out_valid=1 and out_ready=0, at, none_hot and multi_hot hold stable and in_ready=0.
- Encoding for exactly one bit k set: at=k+1, none_hot=0, multi_hot=0. The last-valid register updates to k+1.
- Encoding for zero bits set: none_hot=1, multi_hot=0, at=0 (see Optional Feature).
- Encoding for multiple bits set: multi_hot=1, none_hot=0, at = (lowest set index)+1, i.e. lowest-index priority (see Optional Feature).
- err_count increments by 1 on each accepted none_hot or multi_hot vector. It saturates at 2**ERR_CNT_W-1 and never wraps. It is cleared only by rst.
- Bits of en_vec are ignored when no accept occurs; X on en_vec while in_valid=0 must not propagate.
- Width rule: the index is computed in AT_W bits. The bit-14 result is 4'd15 with no overflow.

Optional Feature:
- Macro: ONEHOT_ENC_HOLD_LAST_EN.
- Defined: for a malformed vector (none-hot or multi-hot), at outputs the last-valid register, i.e. the most recent well-formed index accepted since reset (0 if none yet). Flags and err_count behave identically to the undefined case.
- Undefined: at=0 for none-hot and the lowest-index encoding for multi-hot, as specified above. The last-valid register may be optimised away.

Test Plan:
- Reset then walk: send en_vec=1<<k for k=0..14 with out_ready=1 held -> at=1..15 one cycle after each accept, flags 0, err_count=0, in_ready=1 throughout.
- Malformed vectors: send 15'h0000 then 15'h0014 -> first result at=0, none_hot=1; second result at=3, multi_hot=1; err_count=2. With ONEHOT_ENC_HOLD_LAST_EN, after a prior 15'h0100, both results give at=9.
- Backpressure: accept 15'h0040, then hold out_ready=0 for 5 cycles with in_valid=1 and en_vec=15'h0002 -> at=7 stable, in_ready=0 for all 5 cycles; release -> at=7 consumed, and at=2 appears the next cycle.
- Back-to-back with simultaneous consume/accept: 4 consecutive vectors with in_valid=1 and out_ready=1 -> 4 results on 4 consecutive cycles, no gaps and no duplicates.
- Saturation: with ERR_CNT_W=8, send 300 all-zero vectors -> err_count reaches 255 and stays at 255.
- Mid-operation reset: assert rst for 1 cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_count=0, and in_ready=0 during the rst cycle.
